// File: rtl/sme_job_sched.sv
// Round-robin job scheduler sharing one string-matching engine between NREQ byte-stream requesters.
// Latency: an accepted beat reaches the SME pins one edge later; the result is presented the cycle after sme_valid.
// Backpressure: the grant is held while a requester stalls; while RESP waits on res_ready, no requester is accepted.
// Optional feature: define SME_STRING_REUSE_EN to allow pattern-only jobs against a string already loaded.
module sme_job_sched #(
    parameter int NREQ    = 2,
    parameter int MAX_STR = 32,
    parameter int MAX_PAT = 8,
    parameter int TIMEOUT = 1024,
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     in_valid,
    output logic [NREQ-1:0]     in_ready,
    input  logic [8*NREQ-1:0]   in_data,
    input  logic [NREQ-1:0]     in_last,
    input  logic [NREQ-1:0]     in_kind,
    output logic [7:0]          sme_chardata,
    output logic                sme_isstring,
    output logic                sme_ispattern,
    input  logic                sme_valid,
    input  logic                sme_match,
    input  logic [4:0]          sme_match_index,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [IDW-1:0]      res_id,
    output logic                res_match,
    output logic [4:0]          res_index,
    output logic                res_err
);

    localparam int SCW = $clog2(MAX_STR + 1);
    localparam int PCW = $clog2(MAX_PAT + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STR,
        S_PAT,
        S_WAIT,
        S_RESP
`ifdef SME_STRING_REUSE_EN
        , S_DRAIN
`endif
    } state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    grant, rr_ptr, pick;
    logic              found;
    logic              busy_in;
    logic              beat_vld, beat_last;
    logic [7:0]        beat_dat;
    logic [SCW-1:0]    str_cnt;
    logic [PCW-1:0]    pat_cnt;
    logic [TCW-1:0]    tmo_cnt;
    logic              err;
    logic              str_room, pat_room, tmo_hit;
    int                idx;

`ifdef SME_STRING_REUSE_EN
    logic              owner_vld;
    logic [IDW-1:0]    owner;
`else
    logic              unused_kind;
    assign unused_kind = ^in_kind;
`endif

    // First requesting port at or after rr_ptr, with wrap.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    always_comb begin
        busy_in = (state == S_STR) || (state == S_PAT);
`ifdef SME_STRING_REUSE_EN
        busy_in = busy_in || (state == S_DRAIN);
`endif
        in_ready = '0;
        if (busy_in) in_ready[grant] = 1'b1;
    end

    assign beat_vld  = busy_in && in_valid[grant];
    assign beat_last = in_last[grant];
    assign beat_dat  = in_data[int'(grant)*8 +: 8];
    assign str_room  = str_cnt < SCW'(MAX_STR);
    assign pat_room  = pat_cnt < PCW'(MAX_PAT);
    assign tmo_hit   = tmo_cnt == TCW'(TIMEOUT - 1);

    assign res_valid = (state == S_RESP);
    assign res_id    = grant;
    assign res_err   = err;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (found) begin
`ifdef SME_STRING_REUSE_EN
                if (in_kind[pick])
                    state_nxt = (owner_vld && owner == pick) ? S_PAT : S_DRAIN;
                else
                    state_nxt = S_STR;
`else
                state_nxt = S_STR;
`endif
            end
            S_STR:  if (beat_vld && beat_last) state_nxt = S_PAT;
            S_PAT:  if (beat_vld && beat_last) state_nxt = S_WAIT;
            S_WAIT: if (sme_valid || tmo_hit) state_nxt = S_RESP;
            S_RESP: if (res_ready) state_nxt = S_IDLE;
`ifdef SME_STRING_REUSE_EN
            S_DRAIN: if (beat_vld && beat_last) state_nxt = S_RESP;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            grant         <= '0;
            rr_ptr        <= '0;
            str_cnt       <= '0;
            pat_cnt       <= '0;
            tmo_cnt       <= '0;
            err           <= 1'b0;
            sme_chardata  <= '0;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            res_match     <= 1'b0;
            res_index     <= '0;
`ifdef SME_STRING_REUSE_EN
            owner_vld     <= 1'b0;
            owner         <= '0;
`endif
        end else begin
            state         <= state_nxt;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            if (beat_vld) sme_chardata <= beat_dat;
            case (state)
                S_IDLE: if (found) begin
                    grant   <= pick;
                    rr_ptr  <= (pick == IDW'(NREQ - 1)) ? '0 : pick + 1'b1;
                    str_cnt <= '0;
                    pat_cnt <= '0;
                    tmo_cnt <= '0;
                    err     <= 1'b0;
`ifdef SME_STRING_REUSE_EN
                    // A new string load overwrites whatever the engine held.
                    if (!in_kind[pick]) owner_vld <= 1'b0;
`endif
                end
                S_STR: if (beat_vld) begin
                    if (str_room) begin
                        str_cnt      <= str_cnt + 1'b1;
                        sme_isstring <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
`ifdef SME_STRING_REUSE_EN
                    // Only an untruncated string can be reused later.
                    if (beat_last) begin
                        owner     <= grant;
                        owner_vld <= str_room && !err;
                    end
`endif
                end
                S_PAT: if (beat_vld) begin
                    if (pat_room) begin
                        pat_cnt       <= pat_cnt + 1'b1;
                        sme_ispattern <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (sme_valid) begin
                        res_match <= sme_match;
                        res_index <= sme_match ? sme_match_index : 5'd0;
                    end else if (tmo_hit) begin
                        err       <= 1'b1;
                        res_match <= 1'b0;
                        res_index <= '0;
                    end
                end
`ifdef SME_STRING_REUSE_EN
                S_DRAIN: if (beat_vld && beat_last) begin
                    err       <= 1'b1;
                    res_match <= 1'b0;
                    res_index <= '0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sme_job_sched.sv
// Directed bench for sme_job_sched: drives requester byte streams, models the SME result strobe, checks results.
module tb_sme_job_sched;

    localparam int NREQ = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   in_valid, in_ready, in_last, in_kind;
    logic [8*NREQ-1:0] in_data;
    logic [7:0]        sme_chardata;
    logic              sme_isstring, sme_ispattern;
    logic              sme_valid, sme_match;
    logic [4:0]        sme_match_index;
    logic              res_valid, res_ready;
    logic [0:0]        res_id;
    logic              res_match;
    logic [4:0]        res_index;
    logic              res_err;

    int errors = 0;
    int checks = 0;
    int stall_cnt = 0;
    int str_cyc = 0, pat_cyc = 0, str_sum = 0, pat_sum = 0, overlap = 0;

    always #5 clk = ~clk;

    sme_job_sched #(.NREQ(NREQ)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_kind(in_kind),
        .sme_chardata(sme_chardata), .sme_isstring(sme_isstring), .sme_ispattern(sme_ispattern),
        .sme_valid(sme_valid), .sme_match(sme_match), .sme_match_index(sme_match_index),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_match(res_match), .res_index(res_index), .res_err(res_err)
    );

    // Running tallies of what the engine pins see.
    always @(negedge clk) begin
        if (sme_isstring) begin
            str_cyc <= str_cyc + 1;
            str_sum <= str_sum + int'(sme_chardata);
        end
        if (sme_ispattern) begin
            pat_cyc <= pat_cyc + 1;
            pat_sum <= pat_sum + int'(sme_chardata);
        end
        if (sme_isstring && sme_ispattern) overlap <= overlap + 1;
    end

    function automatic int ssum(input string s);
        int t = 0;
        for (int i = 0; i < s.len(); i++) t += int'(s[i]);
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = '0; in_last = '0; in_kind = '0; in_data = '0;
        sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic hold(input int r, input byte b);
        in_valid[r] = 1'b1;
        in_data[8*r +: 8] = b;
        in_last[r] = 1'b0;
        in_kind[r] = 1'b0;
    endtask

    task automatic beat(input int r, input byte b, input bit last, input bit kind);
        int t;
        t = 0;
        in_valid[r] = 1'b1;
        in_data[8*r +: 8] = b;
        in_last[r] = last;
        in_kind[r] = kind;
        while (in_ready[r] !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        stall_cnt += t;
        chk("beat_ready", 32'(in_ready[r]), 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_job(input int r, input string s, input string p, input bit k0);
        stall_cnt = 0;
        for (int i = 0; i < s.len(); i++)
            beat(r, s[i], i == s.len() - 1, (i == 0) ? k0 : 1'b0);
        for (int i = 0; i < p.len(); i++)
            beat(r, p[i], i == p.len() - 1, (i == 0 && s.len() == 0) ? k0 : 1'b0);
        in_valid[r] = 1'b0;
        in_last[r]  = 1'b0;
        in_kind[r]  = 1'b0;
    endtask

    task automatic sme_pulse(input bit m, input logic [4:0] ix);
        repeat (2) @(negedge clk);
        chk("pre_res", 32'(res_valid), 0);
        sme_valid = 1'b1;
        sme_match = m;
        sme_match_index = ix;
        @(negedge clk);
        sme_valid = 1'b0;
        chk("res_lat", 32'(res_valid), 1);
    endtask

    task automatic get_res(input string tag, input int id, input bit m, input int ix, input bit e);
        int t;
        t = 0;
        while (res_valid !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_vld"}, 32'(res_valid), 1);
        chk({tag, "_id"}, 32'(res_id), id);
        chk({tag, "_match"}, 32'(res_match), 32'(m));
        chk({tag, "_index"}, 32'(res_index), ix);
        chk({tag, "_err"}, 32'(res_err), 32'(e));
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        int s0, p0, ss0, ps0, n, bad;

        do_reset();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_chardata", 32'(sme_chardata), 0);
        chk("rst_isstring", 32'(sme_isstring), 0);
        chk("rst_ispattern", 32'(sme_ispattern), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_id", 32'(res_id), 0);
        chk("rst_res_match", 32'(res_match), 0);
        chk("rst_res_index", 32'(res_index), 0);
        chk("rst_res_err", 32'(res_err), 0);

        // Strobe while idle must be ignored.
        sme_valid = 1'b1; sme_match = 1'b1; sme_match_index = 5'd7;
        @(negedge clk);
        sme_valid = 1'b0;
        @(negedge clk);
        chk("stray_strobe", 32'(res_valid), 0);

        // Single job on req0.
        s0 = str_cyc; p0 = pat_cyc; ss0 = str_sum; ps0 = pat_sum;
        run_job(0, "ABCDEFG", "DEF", 1'b0);
        sme_pulse(1'b1, 5'd3);
        get_res("t1", 0, 1'b1, 3, 1'b0);
        chk("t1_str_cyc", str_cyc - s0, 7);
        chk("t1_pat_cyc", pat_cyc - p0, 3);
        chk("t1_str_sum", str_sum - ss0, ssum("ABCDEFG"));
        chk("t1_pat_sum", pat_sum - ps0, ssum("DEF"));
        chk("t1_overlap", overlap, 0);

        // Both requesters valid from reset: req0 first, then req1.
        do_reset();
        hold(1, "Q");
        run_job(0, "HELLO", "LL", 1'b0);
        sme_pulse(1'b1, 5'd2);
        get_res("t2a", 0, 1'b1, 2, 1'b0);
        run_job(1, "QRS", "RS", 1'b0);
        sme_pulse(1'b0, 5'd9);
        get_res("t2b", 1, 1'b0, 0, 1'b0);

        // req0 alone moves the pointer to req1; then with both asking, req1 wins.
        run_job(0, "MN", "N", 1'b0);
        sme_pulse(1'b1, 5'd1);
        get_res("t2c", 0, 1'b1, 1, 1'b0);
        hold(0, "S");
        run_job(1, "UV", "V", 1'b0);
        sme_pulse(1'b1, 5'd4);
        get_res("t2d", 1, 1'b1, 4, 1'b0);
        run_job(0, "ST", "T", 1'b0);
        sme_pulse(1'b0, 5'd0);
        get_res("t2e", 0, 1'b0, 0, 1'b0);

        // Overlength string: 40 beats accepted, 32 forwarded.
        s0 = str_cyc; p0 = pat_cyc;
        run_job(0, "0123456789012345678901234567890123456789", "AB", 1'b0);
        chk("t3_stalls", stall_cnt, 1);
        sme_pulse(1'b1, 5'd5);
        get_res("t3", 0, 1'b1, 5, 1'b1);
        chk("t3_str_cyc", str_cyc - s0, 32);
        chk("t3_pat_cyc", pat_cyc - p0, 2);

        // Engine never answers: timeout.
        run_job(1, "XY", "Y", 1'b0);
        n = 0;
        while (res_valid !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_latency", 32'(n == 1024 || n == 1025), 1);
        get_res("t4", 1, 1'b0, 0, 1'b1);

        // Result backpressure with another requester waiting.
        run_job(0, "ABC", "C", 1'b0);
        sme_pulse(1'b1, 5'd2);
        hold(1, "K");
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_id !== 1'b0 || res_match !== 1'b1 ||
                res_index !== 5'd2 || res_err !== 1'b0 || in_ready !== '0)
                bad++;
        end
        chk("t5_stable", bad, 0);
        get_res("t5", 0, 1'b1, 2, 1'b0);
        run_job(1, "KL", "L", 1'b0);
        sme_pulse(1'b0, 5'd0);
        get_res("t5b", 1, 1'b0, 0, 1'b0);

`ifdef SME_STRING_REUSE_EN
        do_reset();
        run_job(0, "ABAB", "B", 1'b0);
        sme_pulse(1'b1, 5'd0);
        get_res("t6a", 0, 1'b1, 0, 1'b0);
        s0 = str_cyc; p0 = pat_cyc;
        run_job(0, "", "AB", 1'b1);
        chk("t6b_stalls", stall_cnt, 1);
        sme_pulse(1'b1, 5'd0);
        get_res("t6b", 0, 1'b1, 0, 1'b0);
        chk("t6b_str_cyc", str_cyc - s0, 0);
        chk("t6b_pat_cyc", pat_cyc - p0, 2);
        s0 = str_cyc; p0 = pat_cyc;
        run_job(1, "", "ZZ", 1'b1);
        get_res("t6c", 1, 1'b0, 0, 1'b1);
        chk("t6c_str_cyc", str_cyc - s0, 0);
        chk("t6c_pat_cyc", pat_cyc - p0, 0);
`else
        // in_kind must be ignored: still a string-then-pattern job.
        s0 = str_cyc; p0 = pat_cyc;
        run_job(0, "WXY", "Y", 1'b1);
        sme_pulse(1'b1, 5'd4);
        get_res("t6", 0, 1'b1, 4, 1'b0);
        chk("t6_str_cyc", str_cyc - s0, 3);
        chk("t6_pat_cyc", pat_cyc - p0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
